// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the I/D memory arbiter
// Rev 1.0
// ------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W_DFLT = 28;
  localparam int DATA_W_DFLT = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arbiter_if : I-cache, D-cache and memory port signal bundle
// Rev 1.0
// ------------------------------------------------------------------
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) ();

  logic              i_mem_read;
  logic              i_mem_write;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side
  modport slave (
    input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
    output i_mem_rdata, i_mem_ready,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Caches plus memory model side
  modport master (
    output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
    input  i_mem_rdata, i_mem_ready,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick2 : two-way round-robin selector with write-back lock override
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick2 import mem_arb_pkg::*; (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_lock_valid,
  input  logic       i_lock_id,
  output logic       o_gnt_id,
  output logic       o_gnt_valid
);

  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_id    = REQ_I;
    if (i_lock_valid && i_req[i_lock_id]) begin
      o_gnt_id = i_lock_id;
    end else if (i_req == 2'b11) begin
      o_gnt_id = ~i_last;
    end else if (i_req[REQ_D]) begin
      o_gnt_id = REQ_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arbiter : shares one 128-bit memory port between I- and D-cache
// Rev 1.0
// ------------------------------------------------------------------
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  parameter bit LOCK_WB = 1'b1
) (
  input  logic         clk,
  input  logic         proc_reset_n,
  mem_arbiter_if.slave bus
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic              r_wb_lock;
  logic              w_wb_lock_nxt;

  logic [1:0]        w_req;
  logic              w_gnt_id;
  logic              w_gnt_valid;

  logic              w_own_rd;
  logic              w_own_wr;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;

  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_i_ready;
  logic              w_d_ready;
  logic [DATA_W-1:0] w_i_rdata;
  logic [DATA_W-1:0] w_d_rdata;

  assign w_req[REQ_I] = bus.i_mem_read | bus.i_mem_write;
  assign w_req[REQ_D] = bus.d_mem_read | bus.d_mem_write;

  // The lock always belongs to the requester that just finished, i.e. r_last.
  rr_pick2 u_pick (
    .i_req        (w_req),
    .i_last       (r_last),
    .i_lock_valid (r_wb_lock),
    .i_lock_id    (r_last),
    .o_gnt_id     (w_gnt_id),
    .o_gnt_valid  (w_gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      r_state   <= ST_IDLE;
      r_last    <= REQ_I;
      r_wb_lock <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_wb_lock <= w_wb_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_wb_lock_nxt = r_wb_lock;
    w_own_rd      = 1'b0;
    w_own_wr      = 1'b0;
    w_own_addr    = '0;
    w_own_wdata   = '0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_addr    = '0;
    w_mem_wdata   = '0;
    w_i_ready     = 1'b0;
    w_d_ready     = 1'b0;
    w_i_rdata     = '0;
    w_d_rdata     = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt   = (w_gnt_id == REQ_D) ? ST_BUSY_D : ST_BUSY_I;
          w_wb_lock_nxt = 1'b0;
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (r_state == ST_BUSY_D) begin
          w_own_rd    = bus.d_mem_read;
          w_own_wr    = bus.d_mem_write;
          w_own_addr  = bus.d_mem_addr;
          w_own_wdata = bus.d_mem_wdata;
          w_d_ready   = bus.mem_ready;
          w_d_rdata   = bus.mem_rdata;
        end else begin
          w_own_rd    = bus.i_mem_read;
          w_own_wr    = bus.i_mem_write;
          w_own_addr  = bus.i_mem_addr;
          w_own_wdata = bus.i_mem_wdata;
          w_i_ready   = bus.mem_ready;
          w_i_rdata   = bus.mem_rdata;
        end

        // Write has priority when the owner raises both strobes.
        w_mem_write = w_own_wr;
        w_mem_read  = w_own_rd & ~w_own_wr;
        w_mem_addr  = w_own_addr;
        w_mem_wdata = w_own_wdata;

        if (bus.mem_ready) begin
          w_state_nxt   = ST_IDLE;
          w_last_nxt    = (r_state == ST_BUSY_D) ? REQ_D : REQ_I;
          w_wb_lock_nxt = LOCK_WB && w_own_wr;
        end else if (!w_own_rd && !w_own_wr) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.i_mem_ready = w_i_ready;
  assign bus.i_mem_rdata = w_i_rdata;
  assign bus.d_mem_ready = w_d_ready;
  assign bus.d_mem_rdata = w_d_rdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 128-bit memory port between the instruction cache and the data cache. It sits between the two cache instances and the slow memory model. It grants one cache at a time and forwards that cache's request and write data to memory. It routes read data and `ready` back to that cache only. An optional write-back lock keeps a dirty-eviction write and the refill read that follows it on the same requester.

## Interface
- `ADDR_W`, 28, block address width (word address minus 2 offset bits).
- `DATA_W`, 128, block width.
- `LOCK_WB`, 1, when 1 a completed write transfer re-grants the same requester if it is still requesting.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `proc_reset_n`  in  1  reset; synchronous and active-low.
- `i_mem_read`, `i_mem_write`  in  1 each  I-cache request.
- `i_mem_addr`  in  `ADDR_W`  I-cache block address.
- `i_mem_wdata`  in  `DATA_W`  I-cache write data.
- `i_mem_rdata`  out  `DATA_W`  read data to I-cache.
- `i_mem_ready`  out  1  completion pulse to I-cache.
- `d_mem_read`, `d_mem_write`, `d_mem_addr`, `d_mem_wdata`, `d_mem_rdata`, `d_mem_ready`: same signals for the D-cache.
- `mem_read`, `mem_write`  out  1 each  request to memory.
- `mem_addr`  out  `ADDR_W`  address to memory.
- `mem_wdata`  out  `DATA_W`  write data to memory.
- `mem_rdata`  in  `DATA_W`  read data from memory.
- `mem_ready`  in  1  memory completion, one-cycle pulse.

## Operation
- **Request protocol.** Each requester holds its read/write level-high until its ready pulse. It drops or changes the request on the edge after the pulse.
- **States.** IDLE, BUSY_I, BUSY_D. There is also a 1-bit `last` register, which records the last requester served.
- **IDLE.** The next state depends on which caches request:
  - Only I requests: go to BUSY_I.
  - Only D requests: go to BUSY_D.
  - Both request: grant the one that is not `last`.
  - Neither requests: stay in IDLE.
- **BUSY_x, forwarding.** Memory outputs are driven combinationally from requester x. `mem_ready` is routed to `x_mem_ready` and `mem_rdata` to `x_mem_rdata`. The other requester sees ready=0 and rdata=0.
- **BUSY_x, completion.** On `mem_ready`, set `last`=x and go to IDLE.
  - Exception: `LOCK_WB`=1, the completed transfer was a write, and x raises a request in the following cycle. In that case the next IDLE evaluation grants x regardless of `last`.
  - The lock is held in a 1-bit `wb_lock` register. It clears on any grant.
- **Read and write both asserted.** The write wins: `mem_write`=1 and `mem_read`=0.
- **Owner abandons.** If the owner drops both read and write while BUSY and `mem_ready`=0, go to IDLE next cycle with no ready issued.
- **Stray ready.** `mem_ready` while IDLE is ignored. No requester ready is produced.
- **Outputs in IDLE.** `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are all 0. All requester ready and rdata outputs are 0.

## Timing
- **Reset values.** On a clock edge with `proc_reset_n`=0: state=IDLE, `last`=I (so D wins the first tie), `wb_lock`=0. All outputs are 0 from the following cycle.
- **Reset mid-transfer.** A reset during a transfer drops the grant. No ready is forwarded after reset.
- **Grant latency.** A request first visible in IDLE at cycle N gets state BUSY and memory request asserted at N+1.
- **Ready path.** `mem_ready` at cycle M appears at `x_mem_ready` in the same cycle (combinational). State is IDLE at M+1. The earliest next memory request is at M+2.
- **Back-to-back.** Between two transfers there is at least one IDLE cycle with the memory request at 0.
- **Fairness.** With continuous requests from both caches, grants alternate. No requester waits more than one other transfer, or two if a locked write-back plus refill pair is in progress.

## Structure
- **Shared package `mem_arb_pkg`.** Holds the state encoding (IDLE=0, BUSY_I=1, BUSY_D=2), the `ADDR_W`/`DATA_W` defaults, and requester IDs (REQ_I=0, REQ_D=1).
- **Sub-module `rr_pick2`.** Combinational two-way round-robin selector. Inputs: `req[1:0]`, `last`, `lock_valid`, `lock_id`. Output: grant id plus a valid bit.
- **Top level.** The FSM, the `last` and `wb_lock` registers, and the forwarding muxes.

## Test plan
- **D read only.** Hold `d_mem_read`=1 with `d_mem_addr`=0x0000123, memory ready after 5 cycles with rdata=0xA5 pattern.
  - `mem_read`=1 and `mem_addr`=0x0000123 from cycle 1.
  - `d_mem_ready` pulses for 1 cycle with that rdata; `i_mem_ready` stays 0.
- **Simultaneous requests after reset.** I and D both request a read at cycle 0.
  - D is served first; I is granted two cycles after D's ready.
  - In the cycle between, `mem_read`=0.
- **Locked write-back.** `LOCK_WB`=1. D issues a write to 0x10, then a read to 0x20; I is requesting throughout.
  - Memory sequence is D write 0x10, then D read 0x20, then I.
  - With `LOCK_WB`=0, I is served between the two D transfers.
- **Abandoned request.** D read granted, then `d_mem_read` drops before ready.
  - State returns to IDLE next cycle.
  - A late `mem_ready` produces no `d_mem_ready` or `i_mem_ready`.
- **Reset mid-transfer.** Pull `proc_reset_n` low for 1 cycle during BUSY_I.
  - All memory outputs are 0 the next cycle.
  - A subsequent tie grants D.
- **Read and write both asserted.** I asserts read and write together.
  - `mem_write`=1, `mem_read`=0, `mem_wdata` equals `i_mem_wdata`.
